uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver matching the team's UART transmitter frame format: start bit, 8 data bits LSB-first, one parity bit (even/odd selectable), one or two stop bits, line idle-high. It synchronizes the asynchronous serial line and detects the start edge. It samples each bit at its centre using the same clocks-per-bit divisor as the transmitter, and presents each received byte with error flags in a one-entry output buffer under a valid/ready handshake. It sits between the board RX pin and the consuming logic.

## Interface
- BAUD_DIVISOR, 868, clock cycles per bit (100 MHz / 115200); legal range 4..16383; counters are 14 bits wide.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low; clock clk
- rx_in  in  1  asynchronous serial line, idle high
- two_stop  in  1  1 = frame has two stop bits; sampled at start-bit confirmation
- odd_parity  in  1  1 = odd parity, 0 = even; sampled at start-bit confirmation
- rx_ready  in  1  consumer accepts buffered byte when high with rx_valid
- rx_data  out  8  received byte
- rx_valid  out  1  buffer holds an unconsumed byte
- parity_err  out  1  parity mismatch for the byte in rx_data
- frame_err  out  1  a stop bit sampled low for the byte in rx_data
- overrun  out  1  sticky; a frame was discarded because the buffer was full
- busy  out  1  FSM not in IDLE

## Operation
- rx_in passes through a 2-flop synchronizer, reset to 1, giving rx_s. All logic uses rx_s.
- Let D = BAUD_DIVISOR and H = D>>1 (floor).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE is armed only after rx_s has been seen high for at least one cycle. This covers reset, and any frame that ended with rx_s low.
  - Armed IDLE and rx_s == 0 -> START; baud counter cleared.
- START: at count H-1, sample rx_s.
  - rx_s = 1: false start; go to IDLE, no output, no flags.
  - rx_s = 0: latch two_stop and odd_parity, go to DATA, counter cleared.
- DATA: sample every D cycles into the shift register, LSB first. After the 8th bit -> PARITY.
- PARITY: sample p. Expected p = ^data for even, ~^data for odd. parity_err_n = (p != expected). -> STOP1.
- STOP1: sample; frame_err_n = (bit == 0).
  - Latched two_stop = 1 -> STOP2.
  - Otherwise complete the frame.
- STOP2: sample; frame_err_n |= (bit == 0). Complete the frame.
- Frame completion happens in the cycle after the last stop sample. The FSM returns to IDLE and re-arms once rx_s is high.
- Completion with buffer empty, or buffer being consumed that cycle (rx_valid & rx_ready): load rx_data, parity_err and frame_err, and set rx_valid.
- Completion with rx_valid = 1 and rx_ready = 0: discard the new frame, keep the old buffer contents, set overrun.
- Errored frames (parity or framing) are still delivered; only the flags distinguish them.
- Handshake: transfer occurs on any cycle with rx_valid & rx_ready. rx_valid clears next cycle unless reloaded. rx_data and the flags are stable while rx_valid = 1.
- overrun clears on the cycle after the next completed handshake. If a discard happens in that same cycle, overrun stays set.

## Timing
- Reset values: rx_data = 0x00; rx_valid, parity_err, frame_err, overrun and busy = 0; FSM in IDLE, unarmed; synchronizer = 1.
- Asserting rst_n mid-frame aborts the frame immediately, and no partial byte is ever output.
- Define t0 as the first cycle with rx_s = 0 in armed IDLE. busy = 1 from t0+1.
- Sample points (sampling uses the value of rx_s in that cycle):
  - start confirm: t0+H
  - data bit i: t0+H+(i+1)·D
  - parity: t0+H+9D
  - stop1: t0+H+10D
  - stop2: t0+H+11D
- rx_valid rises at t0+H+10D+1 with one stop bit, or t0+H+11D+1 with two. busy falls in the same cycle.
- Pin-to-rx_s latency is 2 cycles.
- Back-to-back frames (a new start edge immediately after the stop bit) are received with no lost frame.

## Test plan
- D = 16, even parity, one stop bit, send 0xA5 with p = 0 -> rx_data = 0xA5, rx_valid rises at t0+169, no flags, busy low at that cycle.
- Odd parity, two stop bits, send 0x3C with wrong p = 0 -> parity_err = 1, frame_err = 0, byte delivered at t0+185.
- Stop bit driven low, 0x00 data plus break -> frame_err = 1. No new frame starts until the line returns high, then 0x55 is received cleanly.
- Low glitch of 3 cycles on an idle line -> no rx_valid, busy returns to 0, no flags.
- Hold rx_ready = 0 and send 0x11 then 0x22 -> rx_data stays 0x11 and overrun = 1. Raise rx_ready -> 0x11 accepted, overrun clears, next frame 0x33 is delivered.
- Assert rst_n at mid data bit 4 -> all outputs at reset values. A following 0x7E frame is received correctly; frame completion coincident with rx_ready loads the new byte without overrun.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, even/odd parity, one or two stop bits.
// Samples each bit at its centre and hands bytes over through a one-entry valid/ready buffer.
module uart_rx #(
    parameter int BAUD_DIVISOR = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic       two_stop,
    input  logic       odd_parity,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    // state  | meaning
    // IDLE   | waiting for a start edge (only once the line has been seen high)
    // START  | timing to the centre of the start bit to confirm it
    // DATA   | sampling 8 data bits, LSB first
    // PARITY | sampling the parity bit
    // STOP1  | sampling the first stop bit
    // STOP2  | sampling the second stop bit when enabled
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    localparam logic [13:0] DIV_LAST  = 14'(BAUD_DIVISOR - 1);
    localparam logic [13:0] HALF_LAST = 14'((BAUD_DIVISOR >> 1) - 1);

    state_t      state, state_next;
    logic [1:0]  sync;
    logic        rx_s;
    logic        armed;
    logic [13:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        two_stop_l, odd_l, perr, ferr;
    logic        half_tick, bit_tick, complete, load, discard, ferr_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx_in};
    end
    assign rx_s = sync[1];

    assign half_tick = (cnt == HALF_LAST);
    assign bit_tick  = (cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            IDLE:   if (armed && !rx_s) state_next = START;
            START:  if (half_tick) state_next = rx_s ? IDLE : DATA;
            DATA:   if (bit_tick && bit_cnt == 3'd7) state_next = PARITY;
            PARITY: if (bit_tick) state_next = STOP1;
            STOP1: begin
                if (bit_tick) begin
                    if (two_stop_l) begin
                        state_next = STOP2;
                    end else begin
                        state_next = IDLE;
                        complete   = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_tick) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load     = complete && (!rx_valid || rx_ready);
    assign discard  = complete && rx_valid && !rx_ready;
    assign ferr_new = ((state == STOP2) && ferr) || !rx_s;
    assign busy     = (state != IDLE);

    // Armed only by a high line seen while idle, so a frame ending in a break cannot retrigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= (state == IDLE) && rx_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            two_stop_l <= 1'b0;
            odd_l      <= 1'b0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (state == START) begin
            cnt     <= half_tick ? 14'd0 : cnt + 14'd1;
            bit_cnt <= '0;
            if (half_tick && !rx_s) begin
                two_stop_l <= two_stop;
                odd_l      <= odd_parity;
            end
        end else begin
            cnt <= bit_tick ? 14'd0 : cnt + 14'd1;
            if (bit_tick) begin
                if (state == DATA) begin
                    shift   <= {rx_s, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == PARITY) perr <= (rx_s != (odd_l ? ~^shift : ^shift));
                if (state == STOP1)  ferr <= !rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load) begin
                rx_data    <= shift;
                rx_valid   <= 1'b1;
                parity_err <= perr;
                frame_err  <= ferr_new;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (discard)                  overrun <= 1'b1;
            else if (rx_valid && rx_ready) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with D = 16: latency, parity/framing, glitch, overrun and reset cases.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       two_stop = 1'b0;
    logic       odd_parity = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun, busy;

    uart_rx #(.BAUD_DIVISOR(D)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .two_stop(two_stop),
        .odd_parity(odd_parity), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;
    int t_edge = 0;

    int         rise_cnt = 0;
    int         rise_cyc = 0;
    logic [7:0] rise_data = '0;
    logic       rise_perr = 1'b0, rise_ferr = 1'b0, rise_busy = 1'b0, rise_prev_busy = 1'b0;
    int         busy_rise_cyc = 0;
    logic       prev_valid = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_cnt++;
            rise_cyc       = cyc;
            rise_data      = rx_data;
            rise_perr      = parity_err;
            rise_ferr      = frame_err;
            rise_busy      = busy;
            rise_prev_busy = prev_busy;
        end
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        prev_valid = rx_valid;
        prev_busy  = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic p, input logic stop_val,
                              input int nstop, input int extra_low);
        @(posedge clk); #1;
        rx_in  = 1'b0;
        t_edge = cyc;
        repeat (D) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            repeat (D) @(posedge clk); #1;
        end
        rx_in = p;
        repeat (D) @(posedge clk); #1;
        for (int s = 0; s < nstop; s++) begin
            rx_in = stop_val;
            repeat (D) @(posedge clk); #1;
        end
        if (extra_low > 0) begin
            rx_in = 1'b0;
            repeat (extra_low) @(posedge clk); #1;
        end
        rx_in = 1'b1;
    endtask

    task automatic consume();
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        check("consume_valid_low", rx_valid, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(8);

        // 0xA5, even parity, one stop
        send_frame(8'hA5, 1'b0, 1'b1, 1, 0);
        idle(4);
        check("a5_count", rise_cnt, 1);
        check("a5_latency", rise_cyc - t_edge, 171);
        check("a5_busy_rise", busy_rise_cyc - t_edge, 3);
        check("a5_data", rise_data, 8'hA5);
        check("a5_perr", rise_perr, 1'b0);
        check("a5_ferr", rise_ferr, 1'b0);
        check("a5_busy_at_valid", rise_busy, 1'b0);
        check("a5_busy_before", rise_prev_busy, 1'b1);
        consume();

        // 0x3C, odd parity, two stops, wrong parity bit
        odd_parity = 1'b1;
        two_stop   = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 2, 0);
        odd_parity = 1'b0;
        two_stop   = 1'b0;
        idle(4);
        check("3c_latency", rise_cyc - t_edge, 187);
        check("3c_data", rise_data, 8'h3C);
        check("3c_perr", rise_perr, 1'b1);
        check("3c_ferr", rise_ferr, 1'b0);
        consume();

        // 0x00 with stop low and a break; no retrigger until line returns high
        send_frame(8'h00, 1'b0, 1'b0, 1, 3 * D);
        check("brk_count", rise_cnt, 3);
        check("brk_data", rise_data, 8'h00);
        check("brk_ferr", rise_ferr, 1'b1);
        check("brk_perr", rise_perr, 1'b0);
        check("brk_busy_during", busy, 1'b0);
        consume();
        idle(5);
        send_frame(8'h55, 1'b0, 1'b1, 1, 0);
        idle(4);
        check("55_count", rise_cnt, 4);
        check("55_data", rise_data, 8'h55);
        check("55_ferr", rise_ferr, 1'b0);
        check("55_perr", rise_perr, 1'b0);
        consume();

        // 3-cycle low glitch on idle line
        rc = rise_cnt;
        @(posedge clk); #1 rx_in = 1'b0;
        idle(3);
        rx_in = 1'b1;
        idle(40);
        @(negedge clk);
        check("glitch_count", rise_cnt, rc);
        check("glitch_busy", busy, 1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_perr", parity_err, 1'b0);
        check("glitch_ferr", frame_err, 1'b0);

        // back-to-back 0x11, 0x22 with consumer stalled
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1, 0);
        send_frame(8'h22, 1'b0, 1'b1, 1, 0);
        idle(4);
        @(negedge clk);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ovr_valid_cleared", rx_valid, 1'b0);
        check("ovr_flag_cleared", overrun, 1'b0);
        rc = rise_cnt;
        send_frame(8'h33, 1'b0, 1'b1, 1, 0);
        idle(4);
        check("33_count", rise_cnt, rc + 1);
        check("33_data", rise_data, 8'h33);
        check("33_overrun", overrun, 1'b0);
        rx_ready = 1'b0;

        // reset in the middle of data bit 4 of 0x7E
        @(posedge clk); #1 rx_in = 1'b0;
        idle(D);
        for (int i = 0; i < 4; i++) begin
            rx_in = (i != 0);
            idle(D);
        end
        rx_in = 1'b1;
        idle(D / 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(10);
        rc = rise_cnt;
        send_frame(8'h7E, 1'b0, 1'b1, 1, 0);
        idle(4);
        check("7e_count", rise_cnt, rc + 1);
        check("7e_data", rise_data, 8'h7E);
        check("7e_perr", rise_perr, 1'b0);
        check("7e_ferr", rise_ferr, 1'b0);

        // completion coincident with the handshake of the previous byte
        fork
            send_frame(8'h81, 1'b0, 1'b1, 1, 0);
            begin
                @(posedge clk);
                repeat (170) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk); #1 rx_ready = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (171) @(posedge clk);
                @(negedge clk);
                check("coin_valid", rx_valid, 1'b1);
                check("coin_data", rx_data, 8'h81);
                check("coin_overrun", overrun, 1'b0);
            end
        join
        idle(4);
        @(negedge clk);
        check("coin_data_hold", rx_data, 8'h81);
        check("coin_overrun_hold", overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
